// File: rtl/inverter_pkg.sv
// Shared definitions for the inverter modulation chain: word widths, the
// sequencer state encoding and the V/f amplitude law.
package inverter_pkg;

    localparam int FREQ_W = 16;
    localparam int AMP_W  = 12;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_BOOST = 3'd1,
        ST_RAMP  = 3'd2,
        ST_RUN   = 3'd3,
        ST_DECEL = 3'd4,
        ST_FAULT = 3'd5
    } state_e;

    // The sum is kept FREQ_W+1 wide so a large scaled product plus boost saturates
    // cleanly instead of wrapping inside the AMP_W range.
    function automatic logic [AMP_W-1:0] vf_amp(
        input logic [FREQ_W-1:0] f,
        input logic [7:0]        gain,
        input logic [AMP_W-1:0]  boost,
        input logic [AMP_W-1:0]  amax
    );
        logic [FREQ_W+7:0] prod;
        logic [FREQ_W:0]   sum;
        logic [AMP_W-1:0]  result;
        prod = {8'd0, f} * {{FREQ_W{1'b0}}, gain};
        sum  = {1'b0, prod[FREQ_W+7:8]} + {{(FREQ_W+1-AMP_W){1'b0}}, boost};
        if (sum > {{(FREQ_W+1-AMP_W){1'b0}}, amax}) begin
            result = amax;
        end else begin
            result = sum[AMP_W-1:0];
        end
        return result;
    endfunction

endpackage

// File: rtl/ramp_tick_gen.sv
// Ramp-rate prescaler: one-cycle tick every RAMP_DIV clocks, restartable by a
// synchronous clear so each new sequencer state gets a full tick period.
module ramp_tick_gen #(
    parameter int RAMP_DIV = 50000
) (
    input  logic clk_50,
    input  logic rst,
    input  logic clr_i,
    output logic tick_o
);

    localparam int CW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(RAMP_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick_o = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clr_i || tick_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_50 or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/vf_ramp_sequencer.sv
// Run-time sequencer for the inverter: start/boost/ramp/run/decel/fault control
// of the reference frequency, V/f amplitude and master PWM enable.
module vf_ramp_sequencer
    import inverter_pkg::*;
#(
    parameter int               RAMP_DIV    = 50000,
    parameter logic [FREQ_W-1:0] F_STEP     = FREQ_W'(8),
    parameter logic [FREQ_W-1:0] F_MAX      = FREQ_W'(6000),
    parameter logic [7:0]        VF_GAIN    = 8'd96,
    parameter logic [AMP_W-1:0]  AMP_BOOST  = AMP_W'(200),
    parameter logic [AMP_W-1:0]  AMP_MAX    = AMP_W'(2047),
    parameter int                BOOST_TICKS = 10
) (
    input  logic              clk_50,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic [FREQ_W-1:0] f_target,
    input  logic              fault_in,
    input  logic              fault_clr,
    output logic [FREQ_W-1:0] f_ref,
    output logic [AMP_W-1:0]  amp_ref,
    output logic              pwm_en,
    output logic              at_speed,
    output logic [2:0]        state_o,
    output logic              fault_latched
);

    localparam int BW = (BOOST_TICKS > 1) ? $clog2(BOOST_TICKS + 1) : 1;
    localparam logic [BW-1:0] BOOST_LAST = BW'(BOOST_TICKS - 1);

    state_e            state_q, state_d;
    logic [FREQ_W-1:0] f_ref_q, f_ref_d;
    logic [BW-1:0]     boost_q, boost_d;
    logic [AMP_W-1:0]  amp_q, amp_d;
    logic              pwm_q, pwm_d;
    logic              at_speed_q, at_speed_d;
    logic              fault_q, fault_d;
    logic [FREQ_W-1:0] tgt;
    logic              tick;
    logic              tick_clr;

    assign tgt      = (f_target > F_MAX) ? F_MAX : f_target;
    assign tick_clr = (state_d != state_q);

    ramp_tick_gen #(
        .RAMP_DIV(RAMP_DIV)
    ) u_tick (
        .clk_50(clk_50),
        .rst   (rst),
        .clr_i (tick_clr),
        .tick_o(tick)
    );

    // Event priority is fault_in, then stop, then start, then the ramp tick.
    always_comb begin
        state_d = state_q;
        f_ref_d = f_ref_q;
        boost_d = boost_q;
        if (fault_in) begin
            state_d = ST_FAULT;
            f_ref_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start && !stop) state_d = ST_BOOST;
                end
                ST_BOOST: begin
                    if (stop) begin
                        state_d = ST_DECEL;
                    end else if (tick) begin
                        if (boost_q == BOOST_LAST) state_d = ST_RAMP;
                        else boost_d = boost_q + 1'b1;
                    end
                end
                ST_RAMP: begin
                    if (stop) begin
                        state_d = ST_DECEL;
                    end else if (tick) begin
                        if ((tgt > f_ref_q) && ((tgt - f_ref_q) > F_STEP)) begin
                            f_ref_d = f_ref_q + F_STEP;
                        end else if ((tgt < f_ref_q) && ((f_ref_q - tgt) > F_STEP)) begin
                            f_ref_d = f_ref_q - F_STEP;
                        end else begin
                            f_ref_d = tgt;
                            state_d = ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (stop) state_d = ST_DECEL;
                    else if (tick && (f_ref_q != tgt)) state_d = ST_RAMP;
                end
                ST_DECEL: begin
                    if (start && !stop) begin
                        state_d = ST_RAMP;
                    end else if (tick) begin
                        f_ref_d = (f_ref_q > F_STEP) ? (f_ref_q - F_STEP) : '0;
                        if (f_ref_d == '0) state_d = ST_IDLE;
                    end
                end
                ST_FAULT: begin
                    if (fault_clr) state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                    f_ref_d = '0;
                end
            endcase
        end
        if (state_d != state_q) boost_d = '0;
    end

    // Amplitude tracks the already-registered f_ref, giving it one cycle of lag.
    always_comb begin
        amp_d = '0;
        pwm_d = 1'b0;
        if ((state_d != ST_IDLE) && (state_d != ST_FAULT)) begin
            amp_d = vf_amp(f_ref_q, VF_GAIN, AMP_BOOST, AMP_MAX);
            pwm_d = 1'b1;
        end
        at_speed_d = (state_d == ST_RUN) && (f_ref_d == tgt);
        fault_d    = (state_d == ST_FAULT);
    end

    always_ff @(posedge clk_50 or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            f_ref_q    <= '0;
            boost_q    <= '0;
            amp_q      <= '0;
            pwm_q      <= 1'b0;
            at_speed_q <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            f_ref_q    <= f_ref_d;
            boost_q    <= boost_d;
            amp_q      <= amp_d;
            pwm_q      <= pwm_d;
            at_speed_q <= at_speed_d;
            fault_q    <= fault_d;
        end
    end

    assign f_ref         = f_ref_q;
    assign amp_ref       = amp_q;
    assign pwm_en        = pwm_q;
    assign at_speed      = at_speed_q;
    assign state_o       = state_q;
    assign fault_latched = fault_q;

endmodule

// File: tb/tb_vf_ramp_sequencer.sv
// Self-checking bench for vf_ramp_sequencer: vector table plus scoreboard,
// with two extra instances exercising other gain/saturation settings.
module tb_vf_ramp_sequencer;
    import inverter_pkg::*;

    typedef struct {
        string name;
        int    st;
        int    f;
        int    pwm;
        int    at;
        int    flt;
        int    chkAmp;
        int    amp;
    } exp_t;

    typedef struct {
        int   start;
        int   stop;
        int   faultIn;
        int   faultClr;
        int   fTarget;
        int   waitCycles;
        exp_t exp;
    } vec_t;

    logic              clk_50 = 1'b0;
    logic              rst;
    logic              start;
    logic              stop;
    logic              fault_in;
    logic              fault_clr;
    logic [FREQ_W-1:0] f_target;

    logic [FREQ_W-1:0] f_ref, gF, sF;
    logic [AMP_W-1:0]  amp_ref, gAmp, sAmp;
    logic              pwm_en, gPwm, sPwm;
    logic              at_speed, gAt, sAt;
    logic [2:0]        state_o, gSt, sSt;
    logic              fault_latched, gFlt, sFlt;

    int   checks = 0;
    int   passed = 0;
    exp_t sbQ[$];
    vec_t vecs[$];

    always #10 clk_50 = ~clk_50;

    vf_ramp_sequencer #(
        .RAMP_DIV(4), .F_STEP(16'd10), .F_MAX(16'd500), .VF_GAIN(8'd128),
        .AMP_BOOST(12'd100), .AMP_MAX(12'd2047), .BOOST_TICKS(2)
    ) u_dut (
        .clk_50(clk_50), .rst(rst), .start(start), .stop(stop), .f_target(f_target),
        .fault_in(fault_in), .fault_clr(fault_clr), .f_ref(f_ref), .amp_ref(amp_ref),
        .pwm_en(pwm_en), .at_speed(at_speed), .state_o(state_o), .fault_latched(fault_latched)
    );

    vf_ramp_sequencer #(
        .RAMP_DIV(4), .F_STEP(16'd10), .F_MAX(16'd500), .VF_GAIN(8'd255),
        .AMP_BOOST(12'd100), .AMP_MAX(12'd2047), .BOOST_TICKS(2)
    ) u_gain (
        .clk_50(clk_50), .rst(rst), .start(start), .stop(stop), .f_target(f_target),
        .fault_in(fault_in), .fault_clr(fault_clr), .f_ref(gF), .amp_ref(gAmp),
        .pwm_en(gPwm), .at_speed(gAt), .state_o(gSt), .fault_latched(gFlt)
    );

    vf_ramp_sequencer #(
        .RAMP_DIV(4), .F_STEP(16'd10), .F_MAX(16'd500), .VF_GAIN(8'd255),
        .AMP_BOOST(12'd100), .AMP_MAX(12'd300), .BOOST_TICKS(2)
    ) u_sat (
        .clk_50(clk_50), .rst(rst), .start(start), .stop(stop), .f_target(f_target),
        .fault_in(fault_in), .fault_clr(fault_clr), .f_ref(sF), .amp_ref(sAmp),
        .pwm_en(sPwm), .at_speed(sAt), .state_o(sSt), .fault_latched(sFlt)
    );

    function automatic exp_t mkExp(string n, int st, int f, int pwm, int at, int flt,
                                   int chkAmp, int amp);
        exp_t e;
        e.name = n; e.st = st; e.f = f; e.pwm = pwm; e.at = at; e.flt = flt;
        e.chkAmp = chkAmp; e.amp = amp;
        return e;
    endfunction

    function automatic vec_t mkVec(int s, int sp, int fi, int fc, int ft, int w, exp_t e);
        vec_t v;
        v.start = s; v.stop = sp; v.faultIn = fi; v.faultClr = fc;
        v.fTarget = ft; v.waitCycles = w; v.exp = e;
        return v;
    endfunction

    task automatic check(string name, int act, int exp);
        checks++;
        if (act == exp) passed++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic checkOutput();
        exp_t e;
        if (sbQ.size() == 0) begin
            checks++;
            $display("[TB] FAIL scoreboard_empty: got 0 entries, expected 1");
            return;
        end
        e = sbQ.pop_front();
        check({e.name, "_state"}, int'(state_o), e.st);
        check({e.name, "_fref"}, int'(f_ref), e.f);
        check({e.name, "_pwm"}, int'(pwm_en), e.pwm);
        check({e.name, "_atspeed"}, int'(at_speed), e.at);
        check({e.name, "_fault"}, int'(fault_latched), e.flt);
        if (e.chkAmp != 0) check({e.name, "_amp"}, int'(amp_ref), e.amp);
    endtask

    task automatic expectNow(exp_t e);
        sbQ.push_back(e);
        checkOutput();
    endtask

    // Inputs change on the falling edge; pulses last exactly one cycle.
    task automatic applyStimulus(vec_t v);
        start     = (v.start != 0);
        stop      = (v.stop != 0);
        fault_in  = (v.faultIn != 0);
        fault_clr = (v.faultClr != 0);
        f_target  = FREQ_W'(v.fTarget);
        sbQ.push_back(v.exp);
        @(negedge clk_50);
        start     = 1'b0;
        stop      = 1'b0;
        fault_clr = 1'b0;
        repeat (v.waitCycles - 1) @(negedge clk_50);
        checkOutput();
    endtask

    task automatic runVecs();
        for (int i = 0; i < vecs.size(); i++) applyStimulus(vecs[i]);
        vecs.delete();
    endtask

    task automatic waitUntil(string n, int st, int f, int chkF, int bound);
        int ok;
        ok = 0;
        for (int k = 0; k < bound; k++) begin
            @(negedge clk_50);
            if ((int'(state_o) == st) && ((chkF == 0) || (int'(f_ref) == f))) begin
                ok = 1;
                break;
            end
        end
        check(n, ok, 1);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; fault_in = 1'b0; fault_clr = 1'b0;
        f_target = '0;
        #35;
        expectNow(mkExp("reset", 0, 0, 0, 0, 0, 1, 0));
        @(negedge clk_50);
        rst = 1'b0;
        @(negedge clk_50);

        // Start, boost, ramp to 35, then controlled stop back to IDLE.
        vecs.push_back(mkVec(1, 0, 0, 0, 35, 1, mkExp("boost_entry", 1, 0, 1, 0, 0, 1, 100)));
        vecs.push_back(mkVec(0, 0, 0, 0, 35, 7, mkExp("boost_hold", 1, 0, 1, 0, 0, 1, 100)));
        vecs.push_back(mkVec(0, 0, 0, 0, 35, 1, mkExp("ramp_entry", 2, 0, 1, 0, 0, 1, 100)));
        vecs.push_back(mkVec(0, 0, 0, 0, 35, 3, mkExp("ramp_pre_tick", 2, 0, 1, 0, 0, 1, 100)));
        vecs.push_back(mkVec(0, 0, 0, 0, 35, 1, mkExp("ramp_10", 2, 10, 1, 0, 0, 1, 100)));
        vecs.push_back(mkVec(0, 0, 0, 0, 35, 1, mkExp("amp_10", 2, 10, 1, 0, 0, 1, 105)));
        vecs.push_back(mkVec(0, 0, 0, 0, 35, 3, mkExp("ramp_20", 2, 20, 1, 0, 0, 1, 105)));
        vecs.push_back(mkVec(0, 0, 0, 0, 35, 4, mkExp("ramp_30", 2, 30, 1, 0, 0, 1, 110)));
        vecs.push_back(mkVec(0, 0, 0, 0, 35, 4, mkExp("run_35", 3, 35, 1, 1, 0, 1, 115)));
        vecs.push_back(mkVec(0, 0, 0, 0, 35, 1, mkExp("amp_35", 3, 35, 1, 1, 0, 1, 117)));
        vecs.push_back(mkVec(0, 1, 0, 0, 35, 1, mkExp("decel_entry", 4, 35, 1, 0, 0, 1, 117)));
        vecs.push_back(mkVec(0, 0, 0, 0, 35, 4, mkExp("decel_25", 4, 25, 1, 0, 0, 1, 117)));
        vecs.push_back(mkVec(0, 0, 0, 0, 35, 4, mkExp("decel_15", 4, 15, 1, 0, 0, 1, 112)));
        vecs.push_back(mkVec(0, 0, 0, 0, 35, 4, mkExp("decel_5", 4, 5, 1, 0, 0, 1, 107)));
        vecs.push_back(mkVec(0, 0, 0, 0, 35, 4, mkExp("decel_idle", 0, 0, 0, 0, 0, 1, 0)));
        runVecs();

        // Target clamp and amplitude law on all three gain/saturation settings.
        start = 1'b1; f_target = 16'd4000;
        @(negedge clk_50);
        start = 1'b0;
        waitUntil("reach_clamp", 3, 500, 1, 600);
        expectNow(mkExp("clamp", 3, 500, 1, 1, 0, 0, 0));
        @(negedge clk_50);
        check("amp_gain128", int'(amp_ref), 350);
        check("amp_gain255", int'(gAmp), 598);
        check("amp_saturated", int'(sAmp), 300);
        f_target = 16'd480;
        @(negedge clk_50);
        expectNow(mkExp("tgt_change", 3, 500, 1, 0, 0, 0, 0));
        waitUntil("reach_480", 3, 480, 1, 100);
        expectNow(mkExp("run_480", 3, 480, 1, 1, 0, 0, 0));

        // Fault trip from RAMP, ignored clear while tripped, then clean exit.
        f_target = 16'd300;
        waitUntil("enter_ramp", 2, 0, 0, 20);
        vecs.push_back(mkVec(0, 0, 1, 0, 300, 1, mkExp("fault_entry", 5, 0, 0, 0, 1, 1, 0)));
        vecs.push_back(mkVec(0, 0, 1, 1, 300, 1, mkExp("clr_ignored", 5, 0, 0, 0, 1, 1, 0)));
        vecs.push_back(mkVec(0, 0, 0, 0, 300, 2, mkExp("fault_held", 5, 0, 0, 0, 1, 1, 0)));
        vecs.push_back(mkVec(0, 0, 0, 1, 300, 1, mkExp("fault_exit", 0, 0, 0, 0, 0, 1, 0)));
        vecs.push_back(mkVec(1, 1, 0, 0, 35, 1, mkExp("start_stop_idle", 0, 0, 0, 0, 0, 1, 0)));
        vecs.push_back(mkVec(0, 0, 0, 0, 35, 3, mkExp("idle_hold", 0, 0, 0, 0, 0, 1, 0)));
        runVecs();

        // Re-acceleration requested part-way through a deceleration.
        start = 1'b1;
        @(negedge clk_50);
        start = 1'b0;
        waitUntil("reach_35", 3, 35, 1, 100);
        stop = 1'b1;
        @(negedge clk_50);
        stop = 1'b0;
        waitUntil("decel_to_15", 4, 15, 1, 40);
        vecs.push_back(mkVec(1, 0, 0, 0, 35, 1, mkExp("decel_restart", 2, 15, 1, 0, 0, 0, 0)));
        vecs.push_back(mkVec(0, 0, 0, 0, 35, 3, mkExp("restart_hold", 2, 15, 1, 0, 0, 0, 0)));
        vecs.push_back(mkVec(0, 0, 0, 0, 35, 1, mkExp("restart_25", 2, 25, 1, 0, 0, 0, 0)));
        vecs.push_back(mkVec(0, 0, 0, 0, 35, 4, mkExp("restart_35", 3, 35, 1, 1, 0, 0, 0)));
        runVecs();

        // Asynchronous reset while running at 300.
        f_target = 16'd300;
        waitUntil("reach_300", 3, 300, 1, 400);
        #3 rst = 1'b1;
        #1;
        expectNow(mkExp("async_reset", 0, 0, 0, 0, 0, 1, 0));
        check("async_reset_amp_gain255", int'(gAmp), 0);
        @(negedge clk_50);
        rst = 1'b0;
        @(negedge clk_50);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
